sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares the single-port data SRAM between the glyph/display fetch path and the
//  cpu load/store path. Registers one access at a time and drives active-low
//  CE/OE/WE. Display reads have priority; cpu loads/stores fill the remaining slots.
//  Sits between cpu/glyph logic and the SRAM pins in the ASIC top level.
// PARAMETERS
//  ADDR_W          16  SRAM address width
//  DATA_W          16  SRAM data width
//  ACC_CYCLES      2   cycles per SRAM access, must be >= 2
//  MAX_DISP_BURST  4   back-to-back display grants before the cpu is forced a slot (fairness only)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  rst         in   1       reset, synchronous, active-low
//  disp_req    in   1       display read request, held until disp_gnt
//  disp_addr   in   ADDR_W  display read address (glyph_addr)
//  disp_gnt    out  1       1-cycle pulse: display request accepted
//  disp_rvalid out  1       1-cycle pulse: disp_rdata valid
//  disp_rdata  out  DATA_W  display read data, held until next display read
//  cpu_req     in   1       cpu access request, held until cpu_gnt
//  cpu_we      in   1       1 = store, 0 = load
//  cpu_addr    in   ADDR_W  cpu access address
//  cpu_wdata   in   DATA_W  cpu store data
//  cpu_gnt     out  1       1-cycle pulse: cpu request accepted
//  cpu_rvalid  out  1       1-cycle pulse: cpu_rdata valid (loads only)
//  cpu_rdata   out  DATA_W  cpu load data, held until next cpu load
//  sram_ce_n   out  1       SRAM chip enable, active-low
//  sram_oe_n   out  1       SRAM output enable, active-low
//  sram_we_n   out  1       SRAM write enable, active-low
//  sram_addr   out  ADDR_W  SRAM address
//  sram_din    out  DATA_W  data to SRAM
//  sram_dout   in   DATA_W  data from SRAM
// BEHAVIOUR
//  - Reset (rst==0 at an edge): state=IDLE, access counter=0, burst counter=0.
//    ce_n=oe_n=we_n=1. addr, din, rdata buses=0. gnt and rvalid=0.
//    Reset mid-access aborts the access. No rvalid is produced for it.
//  - FSM IDLE: arbitrate on the sampled reqs. disp_req wins. Otherwise cpu_req wins.
//    With no req, stay IDLE. Winner -> ACC. Addr, we and wdata latched. Owner recorded.
//  - FSM ACC: lasts exactly ACC_CYCLES cycles (counter 0..ACC_CYCLES-1), then -> IDLE.
//  - gnt is registered. It is high in the first ACC cycle only.
//    The requester may change req/addr/wdata from the cycle after gnt.
//  - In ACC: ce_n=0 and sram_addr=latched addr.
//    Read: oe_n=0 all ACC cycles, we_n=1.
//    Write: oe_n=1. we_n=0 in ACC cycles 0..ACC_CYCLES-2 and 1 in the last cycle
//    (address/data hold). sram_din=wdata for the whole access and 0 otherwise.
//  - In IDLE: ce_n=oe_n=we_n=1.
//  - Read data: sram_dout is sampled at the edge ending the last ACC cycle into the
//    owner's rdata. The owner's rvalid is high in the following (IDLE) cycle.
//  - Latency: req sampled at edge k -> gnt in cycle k+1 -> rvalid in cycle k+ACC_CYCLES+1.
//    Max throughput is 1 access per ACC_CYCLES+1 cycles.
//  - A req arriving during ACC waits for the next IDLE. A simultaneous disp/cpu req
//    goes to display (subject to fairness).
//  - cpu stores produce no cpu_rvalid. An rdata of a non-owner port is never disturbed.
// CONFIGURATION
//  SRAM_ARB_FAIRNESS_EN defined:
//  - burst counter +1 per display grant while cpu_req is high. It is cleared on a
//    cpu grant or when cpu_req is low at arbitration.
//  - When the counter == MAX_DISP_BURST and cpu_req is high, the cpu wins that
//    IDLE arbitration even if disp_req is high.
//  SRAM_ARB_FAIRNESS_EN undefined: strict display priority; cpu may starve. Counter absent.
// TESTING (ACC_CYCLES=2, MAX_DISP_BURST=4)
//  1. Reset: rst=0 for 2 cycles with both reqs high.
//     -> ce_n/oe_n/we_n=1, gnts=0, rvalids=0, rdata=0.
//  2. cpu store addr=16'h0040, wdata=16'h0001.
//     -> cpu_gnt cycle k+1; ce_n=0, we_n=0 in k+1, we_n=1 in k+2; sram_din=16'h0001; no cpu_rvalid.
//  3. Display read addr=16'h1234, sram_dout=16'hBEEF.
//     -> disp_gnt k+1, oe_n=0 k+1..k+2, disp_rvalid k+3 with disp_rdata=16'hBEEF.
//  4. disp_req and cpu_req (load) rise together.
//     -> disp_gnt first. cpu_gnt 3 cycles later. cpu_rdata gets the cpu's sram_dout; disp_rdata unchanged.
//  5. rst=0 during ACC cycle 0 of a read.
//     -> strobes high next edge, no rvalid; after release, IDLE and a new req is served normally.
//  6. disp_req held high plus cpu_req.
//     -> fairness on: 4 disp grants, then cpu_gnt.
//     -> fairness off: cpu_gnt never while disp_req=1.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between the display fetch path and the cpu.
// Display reads win arbitration; cpu loads/stores take the remaining slots. One access
// at a time, ACC_CYCLES cycles long, with active-low CE/OE/WE driven from registered state.
// Optional macro SRAM_ARB_FAIRNESS_EN: after MAX_DISP_BURST display grants with cpu_req
// pending, the cpu is forced the next slot. Undefined: strict display priority.
// Ports:
//   clk, rst (sync, active-low)
//   disp_req/disp_addr -> disp_gnt, disp_rvalid, disp_rdata  (display reads)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_gnt, cpu_rvalid, cpu_rdata (cpu loads/stores)
//   sram_ce_n/oe_n/we_n, sram_addr, sram_din -> SRAM; sram_dout <- SRAM
module sram_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int ACC_CYCLES     = 2,
  parameter int MAX_DISP_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);
  localparam int CW = $clog2(ACC_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(ACC_CYCLES - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;
  if (ACC_CYCLES < 2 || MAX_DISP_BURST < 1) begin : g_bad_cfg
    $error("sram_arbiter: ACC_CYCLES must be >= 2 and MAX_DISP_BURST >= 1");
  end
  logic [0:0]        st;
  logic [CW-1:0]     cnt;
  logic              own_cpu, we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic              force_cpu, pick_disp, pick_cpu, acc, last;
`ifdef SRAM_ARB_FAIRNESS_EN
  localparam int BW = $clog2(MAX_DISP_BURST + 1);
  logic [BW-1:0] burst;
  assign force_cpu = cpu_req && burst == BW'(MAX_DISP_BURST);
  // Counts display wins while the cpu is waiting; any other arbitration outcome clears it.
  always_ff @(posedge clk)
    if (!rst) burst <= '0;
    else if (st == IDLE) burst <= (pick_disp && cpu_req) ? burst + BW'(1) : '0;
`else
  assign force_cpu = 1'b0;
`endif
  assign pick_disp = disp_req && !force_cpu;
  assign pick_cpu  = cpu_req && !pick_disp;
  assign acc       = st == ACC;
  assign last      = cnt == LAST;
  always_ff @(posedge clk) begin
    if (!rst) begin
      st          <= IDLE;
      cnt         <= '0;
      own_cpu     <= 1'b0;
      we_l        <= 1'b0;
      addr_l      <= '0;
      wdata_l     <= '0;
      disp_gnt    <= 1'b0;
      cpu_gnt     <= 1'b0;
      disp_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
      disp_rdata  <= '0;
      cpu_rdata   <= '0;
    end else begin
      disp_gnt    <= 1'b0;
      cpu_gnt     <= 1'b0;
      disp_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
      if (st == IDLE) begin
        if (pick_disp || pick_cpu) begin
          st       <= ACC;
          cnt      <= '0;
          own_cpu  <= pick_cpu;
          we_l     <= pick_cpu && cpu_we;
          addr_l   <= pick_cpu ? cpu_addr : disp_addr;
          wdata_l  <= cpu_wdata;
          disp_gnt <= pick_disp;
          cpu_gnt  <= pick_cpu;
        end
      end else if (last) begin
        st <= IDLE;
        // Only the owning port's read data register is touched.
        if (!we_l && own_cpu) begin
          cpu_rdata  <= sram_dout;
          cpu_rvalid <= 1'b1;
        end
        if (!we_l && !own_cpu) begin
          disp_rdata  <= sram_dout;
          disp_rvalid <= 1'b1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
  // WE is released in the final access cycle so address and data are held past the write.
  assign sram_ce_n = !acc;
  assign sram_oe_n = !(acc && !we_l);
  assign sram_we_n = !(acc && we_l && !last);
  assign sram_addr = acc ? addr_l : '0;
  assign sram_din  = (acc && we_l) ? wdata_l : '0;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter with a behavioural SRAM and read-data scoreboard.
module tb_sram_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic        disp_req = 1'b1, cpu_req = 1'b1, cpu_we = 1'b0;
  logic [15:0] disp_addr = '0, cpu_addr = '0, cpu_wdata = '0;
  logic        disp_gnt, disp_rvalid, cpu_gnt, cpu_rvalid;
  logic [15:0] disp_rdata, cpu_rdata;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] sram_addr, sram_din, sram_dout;
  logic [15:0] mem [0:65535];
  logic [15:0] disp_q[$], cpu_q[$];
  int checks = 0, errors = 0;

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .ACC_CYCLES(2), .MAX_DISP_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  assign sram_dout = mem[sram_addr];
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_din;

  // Scoreboard: every rvalid must match the oldest expected value for that port.
  always @(negedge clk) begin
    logic [15:0] e;
    if (disp_rvalid === 1'b1) begin
      checks++;
      if (disp_q.size() == 0) begin
        errors++;
        $display("FAIL disp_rvalid_unexpected: got rvalid with rdata %h, required no rvalid", disp_rdata);
      end else begin
        e = disp_q.pop_front();
        if (disp_rdata !== e) begin
          errors++;
          $display("FAIL disp_rdata_sb: got %h, required %h", disp_rdata, e);
        end
      end
    end
    if (cpu_rvalid === 1'b1) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_rvalid_unexpected: got rvalid with rdata %h, required no rvalid", cpu_rdata);
      end else begin
        e = cpu_q.pop_front();
        if (cpu_rdata !== e) begin
          errors++;
          $display("FAIL cpu_rdata_sb: got %h, required %h", cpu_rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 111", {sram_ce_n, sram_oe_n, sram_we_n});
    end
    checks++;
    if ({disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt_rvalid: got %b, required 0000", {disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid});
    end
    checks++;
    if ({disp_rdata, cpu_rdata, sram_addr, sram_din} !== 64'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h, required 0", {disp_rdata, cpu_rdata, sram_addr, sram_din});
    end
    disp_req = 1'b0;
    cpu_req  = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_cpu_store();
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h0001;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL store_gnt_early: got %b, required 0", cpu_gnt);
    end
    @(negedge clk);
    checks++;
    if ({cpu_gnt, sram_ce_n, sram_oe_n, sram_we_n, sram_addr, sram_din} !== {4'b1010, 16'h0040, 16'h0001}) begin
      errors++;
      $display("FAIL store_cycle0: got gnt/ce/oe/we %b addr %h din %h, required 1010 0040 0001",
               {cpu_gnt, sram_ce_n, sram_oe_n, sram_we_n}, sram_addr, sram_din);
    end
    step();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 16'h0000;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, sram_ce_n, sram_oe_n, sram_we_n, sram_din} !== {4'b0011, 16'h0001}) begin
      errors++;
      $display("FAIL store_cycle1: got gnt/ce/oe/we %b din %h, required 0011 0001",
               {cpu_gnt, sram_ce_n, sram_oe_n, sram_we_n}, sram_din);
    end
    @(negedge clk);
    checks++;
    if ({sram_ce_n, cpu_rvalid, sram_din} !== {2'b10, 16'h0}) begin
      errors++;
      $display("FAIL store_end: got ce %b rvalid %b din %h, required 1 0 0000", sram_ce_n, cpu_rvalid, sram_din);
    end
    checks++;
    if (mem[16'h0040] !== 16'h0001) begin
      errors++;
      $display("FAIL store_mem: got %h, required 0001", mem[16'h0040]);
    end
  endtask

  task automatic test_disp_read(input logic [15:0] a, input logic [15:0] d);
    disp_q.push_back(d);
    step();
    disp_req = 1'b1; disp_addr = a;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({disp_gnt, sram_ce_n, sram_oe_n, sram_we_n, sram_addr} !== {4'b1001, a}) begin
      errors++;
      $display("FAIL read_cycle0: got gnt/ce/oe/we %b addr %h, required 1001 %h",
               {disp_gnt, sram_ce_n, sram_oe_n, sram_we_n}, sram_addr, a);
    end
    step();
    disp_req = 1'b0; disp_addr = 16'h0000;
    @(negedge clk);
    checks++;
    if ({disp_gnt, sram_oe_n, sram_addr} !== {2'b00, a}) begin
      errors++;
      $display("FAIL read_cycle1: got gnt %b oe %b addr %h, required 0 0 %h", disp_gnt, sram_oe_n, sram_addr, a);
    end
    @(negedge clk);
    checks++;
    if ({disp_rvalid, sram_oe_n, disp_rdata} !== {2'b11, d}) begin
      errors++;
      $display("FAIL read_rvalid: got rvalid %b oe %b rdata %h, required 1 1 %h", disp_rvalid, sram_oe_n, disp_rdata, d);
    end
  endtask

  task automatic test_contention();
    disp_q.push_back(16'h1111);
    cpu_q.push_back(16'h0001);
    step();
    disp_req = 1'b1; disp_addr = 16'h0100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({disp_gnt, cpu_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL contention_first: got disp/cpu gnt %b, required 10", {disp_gnt, cpu_gnt});
    end
    step();
    disp_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL contention_cpu_early: got %b, required 0", cpu_gnt);
    end
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL contention_cpu_gnt: got %b, required 1", cpu_gnt);
    end
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, cpu_rdata, disp_rdata} !== {1'b1, 16'h0001, 16'h1111}) begin
      errors++;
      $display("FAIL contention_rdata: got rvalid %b cpu %h disp %h, required 1 0001 1111", cpu_rvalid, cpu_rdata, disp_rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    step();
    disp_req = 1'b1; disp_addr = 16'h0200;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (disp_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_gnt: got %b, required 1", disp_gnt);
    end
    rst = 1'b0;
    disp_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, disp_gnt, disp_rvalid, disp_rdata} !== {5'b11100, 16'h0}) begin
      errors++;
      $display("FAIL abort_strobes: got ce/oe/we/gnt/rvalid %b rdata %h, required 11100 0000",
               {sram_ce_n, sram_oe_n, sram_we_n, disp_gnt, disp_rvalid}, disp_rdata);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({disp_rvalid, sram_ce_n} !== 2'b01) begin
      errors++;
      $display("FAIL abort_after: got rvalid %b ce %b, required 0 1", disp_rvalid, sram_ce_n);
    end
    test_disp_read(16'h1234, 16'hBEEF);
  endtask

  task automatic test_fairness();
    int  nd = 0;
    bit  got = 1'b0;
    logic [15:0] dexp;
    dexp = 16'h0300 ^ 16'h5A5A;
    cpu_q.push_back(16'h0001);
    step();
    disp_req = 1'b1; disp_addr = 16'h0300;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (disp_gnt) begin nd++; disp_q.push_back(dexp); end
      if (cpu_gnt) got = 1'b1;
    end
`ifdef SRAM_ARB_FAIRNESS_EN
    checks++;
    if ({got, nd} !== {1'b1, 32'd4}) begin
      errors++;
      $display("FAIL fairness_burst: got cpu_gnt %b after %0d disp grants, required 1 after 4", got, nd);
    end
    step();
    cpu_req = 1'b0; disp_req = 1'b0;
`else
    checks++;
    if (got !== 1'b0 || nd < 10) begin
      errors++;
      $display("FAIL strict_priority: got cpu_gnt %b with %0d disp grants, required 0 with >=10", got, nd);
    end
    step();
    disp_req = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (disp_gnt) disp_q.push_back(dexp);
      if (cpu_gnt) got = 1'b1;
    end
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL strict_cpu_after: got cpu_gnt %b, required 1", got);
    end
    step();
    cpu_req = 1'b0;
`endif
    repeat (8) @(negedge clk);
    checks++;
    if (disp_q.size() + cpu_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d disp and %0d cpu reads outstanding, required 0", disp_q.size(), cpu_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
    mem[16'h1234] <= 16'hBEEF;
    mem[16'h0100] <= 16'h1111;
    test_reset();
    test_cpu_store();
    test_disp_read(16'h1234, 16'hBEEF);
    test_contention();
    test_reset_mid_access();
    test_fairness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
